// File: rtl/dma_pkg.sv
// Shared constants and state encoding for the write-back DMA.
// Holds AXI attribute constants, burst stride and FSM states.
package dma_pkg;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [3:0]  AXI_CACHE_WR   = 4'b0010;
    localparam logic [2:0]  AXI_SIZE_32    = 3'd2;
    localparam logic [31:0] BURST_BYTES    = 32'd64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_AW,
        S_W,
        S_B
    } wr_state_t;

endpackage

// File: rtl/dma_wr_if.sv
// AXI4 write channel (AW/W/B) bundle between DMA master and memory.
// master: drives AW/W payload and BREADY; slave: the reverse.
interface dma_wr_if #(
    parameter int DW = 32,
    parameter int IW = 4
);
    logic [IW-1:0]   awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic [3:0]      awqos;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [IW-1:0]   bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock,
        output awcache, awprot, awqos, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock,
        input  awcache, awprot, awqos, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bid, bresp, bvalid
    );

endinterface

// File: rtl/dma_wr_fifo.sv
// Synchronous word FIFO buffering packed words ahead of a burst.
// Ports: push/push_data in, pop/pop_data (head) out, count, full.
module dma_wr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        // simultaneous push and pop leaves the count unchanged
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dma_wr.sv
// Write DMA: packs halfword pairs into words, writes 16-beat INCR bursts.
// Ports: start/dst_addr/size config, in_* stream, m_axi master, busy/done/err.
module dma_wr
    import dma_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ID_WIDTH = 4,
    parameter int BURST_MAX        = 16,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dst_addr,
    input  logic [15:0] size,
    input  logic [15:0] in_pd,
    input  logic        in_vld,
    output logic        in_rdy,
    dma_wr_if.master    m_axi,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    wr_state_t   state_q;
    logic [31:0] awaddr_q;
    logic [7:0]  awlen_q, beat_cnt_q;
    logic        awvalid_q, wvalid_q, bready_q;
    logic        busy_q, done_q, err_q;
    logic [16:0] words_rem_q;

    logic        half_q, half_d;
    logic [15:0] lo_q, lo_d;
    logic [16:0] in_rem_q, in_rem_d;

    logic        start_acc, all_in, in_acc, push, pop, fifo_full;
    logic [CW-1:0] fifo_count;
    logic [C_AXI_DATA_WIDTH-1:0] fifo_head;
    logic [16:0] beats, fifo_cnt_x;
    logic        unused_bid;

    assign start_acc  = start & (state_q == S_IDLE);
    assign beats      = (words_rem_q < 17'(BURST_MAX)) ?
                        words_rem_q : 17'(BURST_MAX);
    assign fifo_cnt_x = 17'(fifo_count);
    assign pop        = wvalid_q & m_axi.wready;
    assign unused_bid = ^m_axi.bid;

    // halfword packer: low half first, word pushed on the high half
    always_comb begin
        all_in   = (in_rem_q == '0);
        in_rdy   = busy_q & ~all_in & ~fifo_full;
        in_acc   = in_vld & in_rdy;
        push     = in_acc & half_q;
        half_d   = half_q;
        lo_d     = lo_q;
        in_rem_d = in_rem_q;
        if (start_acc) begin
            half_d   = 1'b0;
            in_rem_d = {1'b0, size} + 17'd1;
        end else if (in_acc) begin
            half_d = ~half_q;
            if (!half_q) begin
                lo_d = in_pd;
            end else begin
                in_rem_d = in_rem_q - 17'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q   <= 1'b0;
            lo_q     <= '0;
            in_rem_q <= '0;
        end else begin
            half_q   <= half_d;
            lo_q     <= lo_d;
            in_rem_q <= in_rem_d;
        end
    end

    dma_wr_fifo #(
        .WIDTH (C_AXI_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({in_pd, lo_q}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    // a burst is only launched once fully buffered, so W never stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            beat_cnt_q  <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            words_rem_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_acc) begin
                        awaddr_q    <= dst_addr;
                        words_rem_q <= {1'b0, size} + 17'd1;
                        err_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (fifo_cnt_x >= beats) begin
                        awlen_q    <= beats[7:0] - 8'd1;
                        beat_cnt_q <= '0;
                        awvalid_q  <= 1'b1;
                        state_q    <= S_AW;
                    end
                end
                S_AW: begin
                    if (m_axi.awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        state_q   <= S_W;
                    end
                end
                S_W: begin
                    if (m_axi.wready) begin
                        if (beat_cnt_q == awlen_q) begin
                            wvalid_q <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= S_B;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                        end
                    end
                end
                S_B: begin
                    if (m_axi.bvalid) begin
                        bready_q    <= 1'b0;
                        words_rem_q <= words_rem_q - beats;
                        if (m_axi.bresp != 2'b00) begin
                            err_q <= 1'b1;
                        end
                        if (words_rem_q == beats) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            awaddr_q <= awaddr_q + BURST_BYTES;
                            state_q  <= S_WAIT;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m_axi.awid    = {C_M_AXI_ID_WIDTH{1'b0}};
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awlen   = awlen_q;
    assign m_axi.awsize  = AXI_SIZE_32;
    assign m_axi.awburst = AXI_BURST_INCR;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = AXI_CACHE_WR;
    assign m_axi.awprot  = 3'd0;
    assign m_axi.awqos   = 4'd0;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = fifo_head;
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = wvalid_q & (beat_cnt_q == awlen_q);
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_dma_wr.sv
// Directed bench for dma_wr with an AXI write slave model.
// Scenario tasks run in sequence; a negedge process drives stream and slave.
module tb_dma_wr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dst_addr;
    logic [15:0] size;
    logic [15:0] in_pd;
    logic        in_vld;
    logic        in_rdy;
    logic        busy;
    logic        done;
    logic        err;

    dma_wr_if #(.DW(32), .IW(4)) axi ();

    dma_wr #(
        .C_AXI_DATA_WIDTH (32),
        .C_M_AXI_ID_WIDTH (4),
        .BURST_MAX        (16),
        .FIFO_DEPTH       (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dst_addr (dst_addr),
        .size     (size),
        .in_pd    (in_pd),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .m_axi    (axi),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    bit          rnd_mode;
    int          err_burst;
    logic [15:0] in_q[$];
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [31:0] mem_img[bit [31:0]];
    int          burst_idx, words_acc, xfer_words, done_cnt;
    int          hw_acc, w_pop, w_left, beat, b_wait, fcnt;
    bit          aw_open, b_pend, b_hs, exp_done;
    logic [31:0] cur_addr;
    logic [7:0]  cur_len;

    function automatic logic [15:0] hw_at(input logic [15:0] b,
                                          input logic [15:0] s,
                                          input int j);
        logic [15:0] jj;
        jj = j[15:0];
        return b + s * jj;
    endfunction

    // stream driver + AXI slave; handshakes are decided at the negedge
    // and take effect at the following posedge
    initial begin
        in_vld = 1'b0; in_pd = '0;
        axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                axi.awready = 1'b0; axi.wready = 1'b0;
                axi.bvalid = 1'b0; axi.bresp = 2'b00;
                in_vld = 1'b0; in_q.delete();
                b_pend = 0; b_hs = 0; aw_open = 0; w_left = 0;
                hw_acc = 0; w_pop = 0; exp_done = 0;
            end else begin
                fcnt = hw_acc / 2 - w_pop;
                if (fcnt >= 16) begin
                    tests++;
                    if (in_rdy !== 1'b0) begin
                        fails++;
                        $display("FAIL fifo_full_in_rdy: got %b want 0", in_rdy);
                    end
                end
                if (exp_done) begin
                    tests++;
                    if (done !== 1'b1 || busy !== 1'b0) begin
                        fails++;
                        $display("FAIL done_timing: done=%b busy=%b want 1/0",
                                 done, busy);
                    end
                    exp_done = 0;
                end else if (done !== 1'b0) begin
                    tests++; fails++;
                    $display("FAIL done_spurious: got %b want 0", done);
                end
                if (done === 1'b1) done_cnt++;
                if (aw_open && w_left > 0) begin
                    tests++;
                    if (axi.wvalid !== 1'b1) begin
                        fails++;
                        $display("FAIL wvalid_gap: got %b want 1", axi.wvalid);
                    end
                end
                if (axi.awvalid === 1'b1 || axi.wvalid === 1'b1) begin
                    tests++;
                    if (axi.awvalid === 1'b1 && axi.wvalid === 1'b1) begin
                        fails++;
                        $display("FAIL aw_w_overlap: got 1 want 0");
                    end
                end
                // B channel
                if (b_hs) begin
                    axi.bvalid = 1'b0; b_hs = 0;
                end
                if (b_pend && !axi.bvalid) begin
                    if (b_wait == 0) begin
                        axi.bvalid = 1'b1;
                        axi.bresp = (burst_idx - 1 == err_burst) ? 2'b10 : 2'b00;
                        b_pend = 0;
                    end else begin
                        b_wait--;
                    end
                end
                if (axi.bvalid && axi.bready) begin
                    b_hs = 1; aw_open = 0;
                    words_acc += int'(cur_len) + 1;
                    if (words_acc == xfer_words) exp_done = 1;
                end
                // AW channel
                axi.awready = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (axi.awvalid && axi.awready) begin
                    aw_addr_q.push_back(axi.awaddr);
                    aw_len_q.push_back(axi.awlen);
                    cur_addr = axi.awaddr; cur_len = axi.awlen;
                    beat = 0; w_left = int'(axi.awlen) + 1;
                    burst_idx++; aw_open = 1;
                end
                // W channel
                axi.wready = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (axi.wvalid && axi.wready && !(aw_open && w_left > 0)) begin
                    tests++; fails++;
                    $display("FAIL w_unexpected: got beat want none");
                end else if (axi.wvalid && axi.wready) begin
                    tests++;
                    if (axi.wlast !== (w_left == 1)) begin
                        fails++;
                        $display("FAIL wlast: got %b want %b beat %0d",
                                 axi.wlast, (w_left == 1), beat);
                    end
                    mem_img[cur_addr + 32'(4 * beat)] = axi.wdata;
                    beat++; w_left--; w_pop++;
                    if (w_left == 0) begin
                        b_pend = 1;
                        b_wait = rnd_mode ? $urandom_range(0, 3) : 0;
                    end
                end
                // halfword stream
                if (in_q.size() > 0) begin
                    in_vld = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
                    in_pd = in_q[0];
                end else begin
                    in_vld = 1'b0;
                end
                if (in_vld && in_rdy) begin
                    void'(in_q.pop_front());
                    hw_acc++;
                end
            end
        end
    end

    task automatic xfer_begin(input logic [31:0] dst, input logic [15:0] sz,
                              input logic [15:0] b, input logic [15:0] s,
                              input bit rnd, input int errb);
        aw_addr_q.delete(); aw_len_q.delete(); mem_img.delete();
        burst_idx = 0; words_acc = 0; done_cnt = 0;
        xfer_words = int'(sz) + 1; err_burst = errb; rnd_mode = rnd;
        for (int j = 0; j < 2 * (int'(sz) + 1); j++) in_q.push_back(hw_at(b, s, j));
        @(negedge clk);
        dst_addr = dst; size = sz; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (done_cnt == 0) begin
            fails++;
            $display("FAIL %s_timeout: got no done want done", name);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_xfer(input string name, input logic [31:0] dst,
                              input logic [15:0] sz, input logic [15:0] b,
                              input logic [15:0] s, input logic exp_err);
        int nb, rem, el;
        logic [31:0] a, w, got;
        nb = (int'(sz) + 16) / 16;
        tests++;
        if (done_cnt !== 1) begin
            fails++;
            $display("FAIL %s_done_cnt: got %0d want 1", name, done_cnt);
        end
        tests++;
        if (aw_addr_q.size() != nb) begin
            fails++;
            $display("FAIL %s_aw_cnt: got %0d want %0d", name, aw_addr_q.size(), nb);
        end else begin
            for (int k = 0; k < nb; k++) begin
                rem = int'(sz) + 1 - 16 * k;
                el = (rem >= 16) ? 15 : rem - 1;
                tests++;
                if (aw_addr_q[k] !== dst + 32'(64 * k) || int'(aw_len_q[k]) != el) begin
                    fails++;
                    $display("FAIL %s_aw%0d: got %h/%0d want %h/%0d", name, k,
                             aw_addr_q[k], aw_len_q[k], dst + 32'(64 * k), el);
                end
            end
        end
        for (int i = 0; i <= int'(sz); i++) begin
            a = dst + 32'(4 * i);
            w = {hw_at(b, s, 2 * i + 1), hw_at(b, s, 2 * i)};
            got = mem_img.exists(a) ? mem_img[a] : 32'hxxxx_xxxx;
            tests++;
            if (got !== w) begin
                fails++;
                $display("FAIL %s_data@%h: got %h want %h", name, a, got, w);
            end
        end
        tests++;
        if (err !== exp_err || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_err_busy: got %b/%b want %b/0", name, err, busy, exp_err);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        tests++;
        if ({axi.awvalid, axi.wvalid, axi.wlast, axi.bready,
             in_rdy, busy, done, err} !== 8'h00) begin
            fails++;
            $display("FAIL %s_ctrl: got %b want 00000000", name,
                     {axi.awvalid, axi.wvalid, axi.wlast, axi.bready,
                      in_rdy, busy, done, err});
        end
        tests++;
        if (axi.awaddr !== 32'h0 || axi.awlen !== 8'h0 || axi.wdata !== 32'h0) begin
            fails++;
            $display("FAIL %s_bus: got %h/%h/%h want 0/0/0", name,
                     axi.awaddr, axi.awlen, axi.wdata);
        end
        tests++;
        if ({axi.awid, axi.awsize, axi.awburst, axi.awlock, axi.awcache,
             axi.awprot, axi.awqos, axi.wstrb} !== {4'h0, 3'd2, 2'b01, 1'b0,
             4'b0010, 3'd0, 4'h0, 4'hF}) begin
            fails++;
            $display("FAIL %s_const: got %h/%h/%h/%h want 2/1/2/F", name,
                     axi.awsize, axi.awburst, axi.awcache, axi.wstrb);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; dst_addr = '0; size = '0;
        rnd_mode = 0; err_burst = -1; done_cnt = 0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("post_reset");
    endtask

    task automatic test_single;
        xfer_begin(32'h1000_0000, 16'd0, 16'h1111, 16'h1111, 0, -1);
        tests++;
        if (busy !== 1'b1 || in_rdy !== 1'b1) begin
            fails++;
            $display("FAIL single_start: busy/in_rdy got %b/%b want 1/1", busy, in_rdy);
        end
        wait_done("single");
        check_xfer("single", 32'h1000_0000, 16'd0, 16'h1111, 16'h1111, 1'b0);
        tests++;
        if (!mem_img.exists(32'h1000_0000) || mem_img[32'h1000_0000] !== 32'h2222_1111
            || aw_len_q.size() != 1 || aw_len_q[0] !== 8'd0) begin
            fails++;
            $display("FAIL single_word: got %h want 22221111 awlen 0",
                     mem_img.exists(32'h1000_0000) ? mem_img[32'h1000_0000] : 32'h0);
        end
    endtask

    task automatic test_full_burst;
        xfer_begin(32'h1000_1000, 16'd15, 16'h0100, 16'h0003, 0, -1);
        wait_done("full");
        check_xfer("full", 32'h1000_1000, 16'd15, 16'h0100, 16'h0003, 1'b0);
    endtask

    task automatic test_multi_burst;
        logic [31:0] ea[3];
        logic [7:0]  el[3];
        ea[0] = 32'h2000_0000; ea[1] = 32'h2000_0040; ea[2] = 32'h2000_0080;
        el[0] = 8'd15; el[1] = 8'd15; el[2] = 8'd7;
        xfer_begin(32'h2000_0000, 16'd39, 16'h5A00, 16'h0101, 0, -1);
        wait_done("multi");
        check_xfer("multi", 32'h2000_0000, 16'd39, 16'h5A00, 16'h0101, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (aw_addr_q.size() <= k || aw_addr_q[k] !== ea[k] || aw_len_q[k] !== el[k]) begin
                fails++;
                $display("FAIL multi_aw_fixed%0d: got %h want %h/%0d", k,
                         (aw_addr_q.size() > k) ? aw_addr_q[k] : 32'h0, ea[k], el[k]);
            end
        end
    endtask

    task automatic test_backpressure;
        xfer_begin(32'h4000_0000, 16'd63, 16'hC001, 16'h0137, 1, -1);
        wait_done("bp");
        check_xfer("bp", 32'h4000_0000, 16'd63, 16'hC001, 16'h0137, 1'b0);
        rnd_mode = 0;
    endtask

    task automatic test_error;
        xfer_begin(32'h5000_0000, 16'd47, 16'h0F00, 16'h0011, 0, 1);
        wait_done("error");
        check_xfer("error", 32'h5000_0000, 16'd47, 16'h0F00, 16'h0011, 1'b1);
        xfer_begin(32'h5000_1000, 16'd0, 16'hBEEF, 16'h0001, 0, -1);
        tests++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL err_clear_on_start: err/busy got %b/%b want 0/1", err, busy);
        end
        wait_done("err_clr");
        check_xfer("err_clr", 32'h5000_1000, 16'd0, 16'hBEEF, 16'h0001, 1'b0);
    endtask

    task automatic test_start_busy_and_reset;
        int n;
        xfer_begin(32'h3000_0000, 16'd39, 16'h7700, 16'h0205, 0, -1);
        n = 0;
        while (aw_addr_q.size() == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        dst_addr = 32'h7000_0000; size = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL start_busy_busy: got %b want 1", busy);
        end
        wait_done("start_busy");
        check_xfer("start_busy", 32'h3000_0000, 16'd39, 16'h7700, 16'h0205, 1'b0);

        // error on burst 0, then reset during the W phase of burst 1
        xfer_begin(32'h6000_0000, 16'd31, 16'h1234, 16'h0102, 0, 0);
        n = 0;
        while (!(burst_idx == 2 && axi.wvalid === 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!(burst_idx == 2 && axi.wvalid === 1'b1) || err !== 1'b1) begin
            fails++;
            $display("FAIL midreset_setup: burst %0d wvalid %b err %b want 2/1/1",
                     burst_idx, axi.wvalid, err);
        end
        #2 rst_n = 1'b0;
        #1 chk_idle_outputs("midreset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        xfer_begin(32'h6000_1000, 16'd0, 16'hABCD, 16'h1111, 0, -1);
        wait_done("recover");
        check_xfer("recover", 32'h6000_1000, 16'd0, 16'hABCD, 16'h1111, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_burst();
        test_multi_burst();
        test_backpressure();
        test_error();
        test_start_busy_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
